rom_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the CPU program ROM. Holds the program counter, issues ROM reads (`rom_en`/`rom_addr`), tracks the ROM's fixed read latency, and buffers returned words so the downstream decoder consumes them through a valid/ready handshake. Supports start/stop via `run` and redirection via `jump_valid`, with squash of in-flight reads.

---
 rtl/rom_fetch_ctrl_pkg.sv | 15 +
 rtl/rom_fetch_ctrl_if.sv | 23 ++
 rtl/rom_fetch_ctrl_fifo.sv | 54 +++++
 rtl/rom_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_rom_fetch_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared types and default sizing for the program-ROM fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_READ_LAT  = 1;
    localparam int DEF_BUF_DEPTH = 2;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// ROM read port plus the instruction valid/ready stream toward the decoder.
interface rom_fetch_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output rom_en, rom_addr, instr_valid, instr_data, instr_pc,
        input  rom_data, instr_ready
    );

    modport slave (
        input  rom_en, rom_addr, instr_valid, instr_data, instr_pc,
        output rom_data, instr_ready
    );
endinterface

// File: rtl/rom_fetch_ctrl_fifo.sv
// Synchronous FIFO holding fetched {data, pc} words; flush beats push and pop.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rom_fetch_ctrl.sv
// Program-ROM fetch sequencer: PC, read issue with credit, latency tracking, jump squash.
//   state | meaning
//   IDLE  | stopped, nothing in flight
//   FETCH | issuing reads whenever buffer credit allows
//   DRAIN | stopped, waiting for in-flight reads to land
module rom_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              busy,
    rom_fetch_ctrl_if.master  bus
);
    localparam int CW = 16;
    localparam int FW = $clog2(BUF_DEPTH + 1);
    localparam int PW = DATA_W + ADDR_W;

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [READ_LAT-1:0] sr_v;
    logic [ADDR_W-1:0] sr_pc [READ_LAT];

    logic [CW-1:0] inflight, inflight_nxt;
    logic [FW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          pop, push, issue, credit_ok, busy_nxt;
    logic [PW-1:0] head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(sr_v[i]);
    end

    assign pop  = bus.instr_valid && bus.instr_ready;
    assign push = sr_v[READ_LAT-1] && !jump_valid;

    // Every outstanding read must already own a buffer slot when it lands.
    assign credit_ok = (inflight + CW'(fifo_count) - CW'(pop)) < CW'(BUF_DEPTH);
    assign issue     = (state == FETCH) && !jump_valid && credit_ok;

    assign bus.rom_en   = issue;
    assign bus.rom_addr = pc;

    assign inflight_nxt = jump_valid ? '0
                        : inflight - CW'(sr_v[READ_LAT-1]) + CW'(issue);

    always_comb begin
        state_nxt = state;
        if (!jump_valid) begin
            case (state)
                IDLE:    if (run) state_nxt = FETCH;
                FETCH:   if (!run) state_nxt = (inflight_nxt != '0) ? DRAIN : IDLE;
                DRAIN:   if (run) state_nxt = FETCH;
                         else if (inflight_nxt == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy_nxt = (state_nxt != IDLE) || (inflight_nxt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
            sr_v  <= '0;
            busy  <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) sr_pc[i] <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            if (jump_valid)  pc <= jump_addr;
            else if (issue) pc <= pc + 1'b1;
            for (int i = READ_LAT - 1; i > 0; i--) begin
                sr_v[i]  <= sr_v[i-1];
                sr_pc[i] <= sr_pc[i-1];
            end
            sr_v[0]  <= issue;
            sr_pc[0] <= pc;
            if (jump_valid) sr_v <= '0;
        end
    end

    fetch_fifo #(.WIDTH(PW), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.rom_data, sr_pc[READ_LAT-1]}),
        .pop       (pop),
        .flush     (jump_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (head)
    );

    assign bus.instr_valid = !fifo_empty;
    assign {bus.instr_data, bus.instr_pc} = head;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full && !pop));
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomized bench for rom_fetch_ctrl against a queue-based reference of the fetch rules.
module tb_rom_fetch_ctrl;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 4;
    localparam int READ_LAT  = 1;
    localparam int BUF_DEPTH = 2;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DRAIN = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic              busy;

    rom_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_fetch_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ROM with fixed read latency; junk on the data bus when no read lands.
    logic [DATA_W-1:0] rom_mem [2**ADDR_W];
    logic              lat_v [READ_LAT];
    logic [ADDR_W-1:0] lat_a [READ_LAT];
    logic [DATA_W-1:0] junk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LAT; i++) lat_v[i] <= 1'b0;
            junk <= '0;
        end else begin
            lat_v[0] <= bus.rom_en;
            lat_a[0] <= bus.rom_addr;
            for (int i = 1; i < READ_LAT; i++) begin
                lat_v[i] <= lat_v[i-1];
                lat_a[i] <= lat_a[i-1];
            end
            junk <= DATA_W'($urandom);
        end
    end

    assign bus.rom_data = lat_v[READ_LAT-1] ? rom_mem[lat_a[READ_LAT-1]] : junk;

    typedef struct {logic [ADDR_W-1:0] pc; int rem;} flight_t;
    typedef struct {logic [DATA_W-1:0] data; logic [ADDR_W-1:0] pc;} word_t;

    flight_t           fl_q[$];
    word_t             wq[$];
    int                m_state;
    logic [ADDR_W-1:0] m_pc;
    bit                m_busy;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl_q.delete();
        wq.delete();
        m_state = M_IDLE;
        m_pc    = '0;
        m_busy  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr_data", bus.instr_data, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic step(input bit r, input bit jv, input logic [ADDR_W-1:0] ja, input bit rdy);
        bit      pop, issue;
        flight_t nq[$];
        flight_t f;
        word_t   w;
        @(negedge clk);
        run             = r;
        jump_valid      = jv;
        jump_addr       = ja;
        bus.instr_ready = rdy;
        #1;
        pop   = (wq.size() > 0) && rdy;
        issue = (m_state == M_FETCH) && !jv
                && ((fl_q.size() + wq.size() - int'(pop)) < BUF_DEPTH);
        chk("rom_en", bus.rom_en, issue);
        chk("rom_addr", bus.rom_addr, m_pc);
        chk("instr_valid", bus.instr_valid, wq.size() > 0);
        if (wq.size() > 0) begin
            chk("instr_data", bus.instr_data, wq[0].data);
            chk("instr_pc", bus.instr_pc, wq[0].pc);
        end
        chk("busy", busy, m_busy);
        @(posedge clk);
        if (jv) begin
            m_pc = ja;
            fl_q.delete();
            wq.delete();
        end else begin
            if (pop) void'(wq.pop_front());
            foreach (fl_q[i]) begin
                f = fl_q[i];
                if (f.rem == 1) begin
                    w.data = rom_mem[f.pc];
                    w.pc   = f.pc;
                    wq.push_back(w);
                end else begin
                    f.rem--;
                    nq.push_back(f);
                end
            end
            if (issue) begin
                f.pc  = m_pc;
                f.rem = READ_LAT;
                nq.push_back(f);
                m_pc = m_pc + 1'b1;
            end
            fl_q = nq;
            case (m_state)
                M_IDLE:  if (r) m_state = M_FETCH;
                M_FETCH: if (!r) m_state = (fl_q.size() != 0) ? M_DRAIN : M_IDLE;
                default: if (r) m_state = M_FETCH;
                         else if (fl_q.size() == 0) m_state = M_IDLE;
            endcase
        end
        m_busy = (m_state != M_IDLE) || (fl_q.size() != 0);
    endtask

    task automatic async_reset(input bit new_rom);
        #2;
        reset           = 1'b0;
        run             = 1'b0;
        jump_valid      = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        if (new_rom)
            for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'($urandom);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        run             = 1'b0;
        jump_valid      = 1'b0;
        jump_addr       = '0;
        bus.instr_ready = 1'b0;
        reset           = 1'b1;
        for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i);
        model_reset();
        #1 reset = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // free run through the PC wrap
        repeat (22) step(1'b1, 1'b0, '0, 1'b1);
        // backpressure
        repeat (5) step(1'b1, 1'b0, '0, 1'b0);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);
        // jump while streaming: same-cycle pop and push are squashed
        step(1'b1, 1'b1, 4'd9, 1'b1);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);
        // jump with a full buffer
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 4'd14, 1'b0);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);
        // stop with words outstanding, then restart at the held PC
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        repeat (5) step(1'b0, 1'b0, '0, 1'b1);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);
        // jump while stopped
        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 4'd3, 1'b1);
        repeat (4) step(1'b1, 1'b0, '0, 1'b1);

        async_reset(1'b1);
        repeat (8) step(1'b1, 1'b0, '0, 1'b1);

        repeat (500)
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
                 ADDR_W'($urandom), ($urandom_range(0, 3) != 0));

        async_reset(1'b1);
        repeat (20) step(1'b1, 1'b0, '0, 1'b1);
        repeat (6) step(1'b0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
